// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding,
// frame start marker and the word positions inside a frame.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_COUNT   = 3'd3,
        ST_DATA    = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } loader_state_t;

    localparam logic [15:0] LOADER_MAGIC = 16'hA55A;

    // Frame layout: MAGIC, ADDR_HI, ADDR_LO, COUNT, COUNT data words, CHECK.
    localparam int unsigned FRAME_IDX_MAGIC   = 0;
    localparam int unsigned FRAME_IDX_ADDR_HI = 1;
    localparam int unsigned FRAME_IDX_ADDR_LO = 2;
    localparam int unsigned FRAME_IDX_COUNT   = 3;
    localparam int unsigned FRAME_IDX_DATA    = 4;

endpackage

// File: rtl/program_loader.sv
// Streams framed program images into instruction memory and holds the
// processor in reset until a frame has been loaded with a good checksum.
//
// Stream handshake: a word transfers on a rising edge where
// in_valid && in_ready are both high. in_ready does not depend on in_valid;
// it is low only while rst is high or after a checksum error.
module program_loader
    import loader_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [15:0]   in_data,
    output logic          in_ready,
    output logic          write_enable,
    output logic [31:0]   write_addr,
    output logic [15:0]   write_data,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_error,
    output loader_state_t dbg_state
);

    loader_state_t state_q;
    loader_state_t state_d;

    logic [31:0] addr_q;
    logic [15:0] count_q;
    logic [15:0] acc_q;

    logic        write_enable_q;
    logic [31:0] write_addr_q;
    logic [15:0] write_data_q;
    logic        cpu_hold_q;
    logic        load_done_q;
    logic        load_error_q;

    logic accept;

    assign in_ready     = !rst && (state_q != ST_ERROR);
    assign accept       = in_valid && in_ready;

    assign write_enable = write_enable_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign dbg_state    = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every move is triggered by an accepted word; ERROR is terminal.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_data == LOADER_MAGIC) state_d = ST_ADDR_HI;
                end
                ST_ADDR_HI: state_d = ST_ADDR_LO;
                ST_ADDR_LO: state_d = ST_COUNT;
                ST_COUNT: begin
                    if (in_data == 16'h0000) state_d = ST_CHECK;
                    else                     state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (count_q == 16'd1) state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (in_data == acc_q) state_d = ST_DONE;
                    else                  state_d = ST_ERROR;
                end
                ST_DONE: begin
                    if (in_data == LOADER_MAGIC) state_d = ST_ADDR_HI;
                end
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs; reset overrides any write pending from the last accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q         <= 32'h0;
            count_q        <= 16'h0;
            acc_q          <= 16'h0;
            write_enable_q <= 1'b0;
            write_addr_q   <= 32'h0;
            write_data_q   <= 16'h0;
            cpu_hold_q     <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
        end else begin
            write_enable_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    ST_ADDR_HI: addr_q[31:16] <= in_data;
                    ST_ADDR_LO: addr_q[15:0]  <= in_data;
                    ST_COUNT: begin
                        count_q <= in_data;
                        acc_q   <= 16'h0;
                    end
                    ST_DATA: begin
                        write_enable_q <= 1'b1;
                        write_addr_q   <= addr_q;
                        write_data_q   <= in_data;
                        addr_q         <= addr_q + 32'd1;
                        count_q        <= count_q - 16'd1;
                        acc_q          <= acc_q ^ in_data;
                    end
                    default: ;
                endcase
            end
            cpu_hold_q   <= (state_d != ST_DONE);
            load_done_q  <= (state_d == ST_DONE);
            load_error_q <= (state_d == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: scenario tasks drive frames, a negedge monitor
// pops expected writes {cycle, addr, data} from a queue and compares them.
module tb_program_loader;
    import loader_pkg::*;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [15:0]   in_data;
    logic          in_ready;
    logic          write_enable;
    logic [31:0]   write_addr;
    logic [15:0]   write_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    loader_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] cyc = 0;
    logic [79:0] exp_q[$];

    program_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .write_enable(write_enable),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_error  (load_error),
        .dbg_state   (dbg_state)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Write monitor: every strobe must match the oldest expected write, in the expected cycle.
    always @(negedge clk) begin
        logic [79:0] e;
        cyc = cyc + 32'd1;
        if (write_enable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cycle=%0d addr=%h data=%h expected no write",
                         cyc, write_addr, write_data);
            end else begin
                e = exp_q.pop_front();
                if ({cyc, write_addr, write_data} !== e) begin
                    errors++;
                    $display("FAIL write cycle/addr/data got %0d/%h/%h expected %0d/%h/%h",
                             cyc, write_addr, write_data, e[79:48], e[47:16], e[15:0]);
                end
            end
        end
    end

    // Drive one word; if accepted and wr is set, expect a write to addr one cycle later.
    task automatic send_word(input logic [15:0] w, input bit wr, input logic [31:0] a);
        logic rdy;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        #1 rdy = in_ready;
        @(posedge clk);
        if (rdy && wr) exp_q.push_back({cyc + 32'd1, a, w});
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 16'($urandom);
        end
    endtask

    task automatic check_status(input string name, input logic hold, input logic done,
                                input logic err, input logic rdy, input loader_state_t st);
        @(negedge clk);
        #1;
        checks++;
        if ({cpu_hold, load_done, load_error, in_ready} !== {hold, done, err, rdy} ||
            dbg_state !== st) begin
            errors++;
            $display("FAIL %s hold/done/err/rdy/state got %b%b%b%b/%0d expected %b%b%b%b/%0d",
                     name, cpu_hold, load_done, load_error, in_ready, dbg_state,
                     hold, done, err, rdy, st);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({write_enable, write_addr, write_data, cpu_hold, load_done, load_error, in_ready}
                !== {1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0} || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL %s we=%b addr=%h data=%h hold=%b done=%b err=%b rdy=%b state=%0d expected reset values",
                     name, write_enable, write_addr, write_data, cpu_hold, load_done,
                     load_error, in_ready, dbg_state);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset_values("reset_values");
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b expected 1", in_ready);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'h0;
        apply_reset();
    endtask

    task automatic test_basic_load();
        send_word(LOADER_MAGIC, 0, 0);
        send_word(16'h0000, 0, 0);
        send_word(16'h0100, 0, 0);
        send_word(16'h0003, 0, 0);
        send_word(16'h1111, 1, 32'h100);
        send_word(16'h2222, 1, 32'h101);
        send_word(16'h4444, 1, 32'h102);
        check_status("basic_hold_during_load", 1, 0, 0, 1, ST_CHECK);
        send_word(16'h7777, 0, 0);
        check_status("basic_done", 0, 1, 0, 1, ST_DONE);
    endtask

    task automatic test_reload();
        send_word(16'hBEEF, 0, 0);
        check_status("done_discards_garbage", 0, 1, 0, 1, ST_DONE);
        send_word(LOADER_MAGIC, 0, 0);
        check_status("reload_hold", 1, 0, 0, 1, ST_ADDR_HI);
        send_word(16'h0000, 0, 0);
        send_word(16'h0300, 0, 0);
        send_word(16'h0002, 0, 0);
        send_word(16'h00F0, 1, 32'h300);
        send_word(16'h0F0F, 1, 32'h301);
        send_word(16'h0FFF, 0, 0);
        check_status("reload_done", 0, 1, 0, 1, ST_DONE);
    endtask

    task automatic test_mid_reset();
        send_word(LOADER_MAGIC, 0, 0);
        send_word(16'h0000, 0, 0);
        send_word(16'h0200, 0, 0);
        send_word(16'h0004, 0, 0);
        send_word(16'h5555, 1, 32'h200);
        // Reset arrives together with the next data word: nothing may be written.
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h6666;
        @(negedge clk);
        #1 check_reset_values("mid_reset_values");
        rst      = 1'b0;
        in_valid = 1'b0;
        send_word(16'h1234, 0, 0);
        check_status("mid_reset_idle", 1, 0, 0, 1, ST_IDLE);
    endtask

    task automatic test_bad_checksum();
        send_word(LOADER_MAGIC, 0, 0);
        send_word(16'h0000, 0, 0);
        send_word(16'h0100, 0, 0);
        send_word(16'h0003, 0, 0);
        send_word(16'h1111, 1, 32'h100);
        send_word(16'h2222, 1, 32'h101);
        send_word(16'h4444, 1, 32'h102);
        send_word(16'h0000, 0, 0);
        check_status("bad_check_error", 1, 0, 1, 0, ST_ERROR);
        send_word(LOADER_MAGIC, 0, 0);
        send_word(16'h9999, 0, 0);
        check_status("error_sticky", 1, 0, 1, 0, ST_ERROR);
        apply_reset();
    endtask

    task automatic test_empty_garbage();
        send_word(16'h1234, 0, 0);
        check_status("garbage_discarded", 1, 0, 0, 1, ST_IDLE);
        send_word(LOADER_MAGIC, 0, 0);
        send_word(16'h0000, 0, 0);
        send_word(16'h0000, 0, 0);
        send_word(16'h0000, 0, 0);
        send_word(16'h0000, 0, 0);
        check_status("empty_done", 0, 1, 0, 1, ST_DONE);
    endtask

    task automatic test_wrap_stalls();
        send_word(LOADER_MAGIC, 0, 0);
        idle(1);
        send_word(16'hFFFF, 0, 0);
        idle(1);
        send_word(16'hFFFF, 0, 0);
        idle(1);
        send_word(16'h0002, 0, 0);
        idle(1);
        send_word(16'h0BAD, 1, 32'hFFFF_FFFF);
        idle(1);
        send_word(16'hCAFE, 1, 32'h0000_0000);
        idle(1);
        send_word(16'h0BAD ^ 16'hCAFE, 0, 0);
        check_status("wrap_done", 0, 1, 0, 1, ST_DONE);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            logic [31:0] base;
            logic [15:0] n;
            logic [15:0] acc;
            logic [15:0] w;
            base = {16'($urandom), 16'($urandom)};
            n    = 16'($urandom_range(1, 6));
            acc  = 16'h0;
            send_word(LOADER_MAGIC, 0, 0);
            send_word(base[31:16], 0, 0);
            send_word(base[15:0], 0, 0);
            send_word(n, 0, 0);
            for (int i = 0; i < int'(n); i++) begin
                w   = 16'($urandom);
                acc = acc ^ w;
                send_word(w, 1, base + 32'(i));
            end
            send_word(acc, 0, 0);
        end
        check_status("back_to_back_done", 0, 1, 0, 1, ST_DONE);
    endtask

    // Scenario sequence and final report.
    initial begin
        test_reset();
        test_basic_load();
        test_reload();
        test_mid_reset();
        test_bad_checksum();
        test_empty_garbage();
        test_wrap_stalls();
        test_back_to_back();
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Streams a program image into instruction memory before and between runs. Drives the fetch stage's instruction-memory write port: `write_enable`, 32-bit `write_addr`, 16-bit `write_data`. Holds the processor in reset while loading. Frames arrive as 16-bit words on a valid/ready stream from the host link or testbench; each frame is header, payload, XOR checksum.

## Interface
- `MAGIC`, 16'hA55A: frame start word.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  stream word present.
- `in_data`  in  16  stream word.
- `in_ready`  out  1  loader accepts word this cycle; transfer occurs when `in_valid && in_ready`.
- `write_enable`  out  1  one-cycle instruction-memory write strobe.
- `write_addr`  out  32  write address (word address).
- `write_data`  out  16  word to write.
- `cpu_hold`  out  1  holds the processor pipeline in reset while high.
- `load_done`  out  1  last frame loaded with good checksum.
- `load_error`  out  1  checksum mismatch; sticky until `rst`.

## Operation
- Frame word order: `MAGIC`, ADDR_HI, ADDR_LO, COUNT, COUNT data words, CHECK. CHECK = XOR of all data words (16'h0000 when COUNT=0).
- FSM states: IDLE, ADDR_HI, ADDR_LO, COUNT, DATA, CHECK, DONE, ERROR. Transitions occur only on an accepted word, except ERROR.
- IDLE: word == MAGIC -> ADDR_HI; any other word is discarded and the FSM stays in IDLE.
- ADDR_HI/ADDR_LO: latch the base address halves. Next state: COUNT.
- COUNT: latch the remaining-word counter (16 bit) and clear the checksum accumulator. COUNT==0 -> CHECK; otherwise -> DATA.
- DATA: each accepted word is written to the current address. Accumulator ^= word; address += 1 (32-bit, 32'hFFFFFFFF wraps to 0); counter -= 1. After the last word -> CHECK.
- CHECK: word == accumulator -> DONE. Otherwise -> ERROR.
- DONE: `load_done`=1, `cpu_hold`=0. An accepted MAGIC starts a new frame: `load_done`=0, `cpu_hold`=1, -> ADDR_HI. Other words are discarded.
- ERROR: `in_ready`=0, `cpu_hold`=1, `load_error`=1. Leaves only on `rst`. Words already written are not rolled back.
- `in_ready`=1 in every state except ERROR.

## Timing
- Reset values: `write_enable`=0, `write_addr`=0, `write_data`=0, `cpu_hold`=1, `load_done`=0, `load_error`=0, state IDLE. `in_ready`=0 while `rst` is high, 1 in the first cycle after.
- Write latency: a data word accepted in cycle N produces `write_enable`=1 in cycle N+1, with `write_addr`/`write_data` registered.
- `write_enable` lasts exactly one cycle per word.
- Back-to-back accepted words produce back-to-back writes; maximum throughput is 1 word/cycle.
- `in_valid` low: no state change, no write.
- `load_done` and `cpu_hold` update in the cycle after the CHECK word is accepted.
- `rst` mid-frame: the next cycle is in reset state, with no write in that cycle even if a data word was accepted in the previous cycle (reset wins over the pending write).

## Structure
- Shared package `loader_pkg`: state enum `loader_state_t`, constant `LOADER_MAGIC` = 16'hA55A, and the frame layout word indices.
- Single module with no sub-module.
- Datapath registers: 32-bit address, 16-bit counter, 16-bit accumulator, plus the output registers.

## Test plan
- Basic load: A55A, 0000, 0100, 0003, 1111, 2222, 4444, 7777 -> writes at 0x100/0x101/0x102 with 1111/2222/4444, one cycle after each accept. `load_done`=1, `cpu_hold`=0.
- Bad checksum: same frame with CHECK=0000 -> three writes, then `load_error`=1, `in_ready`=0, `cpu_hold`=1. After `rst`, all outputs return to reset values.
- Empty payload and garbage: 1234, A55A, 0000, 0000, 0000, 0000 -> 1234 discarded, no writes, `load_done`=1.
- Address wrap with stalls: base FFFF_FFFF, COUNT=2, `in_valid` toggled every other cycle -> writes to FFFF_FFFF then 0000_0000, with no writes in idle cycles.
- Reload and reset: a second frame after DONE re-asserts `cpu_hold` and clears `load_done`. Asserting `rst` mid-DATA suppresses the pending write and returns to IDLE.
